// File: rtl/chase_pkg.sv
// Constants shared by the chase game blocks: banner bitmap geometry, colour
// width and the blink-state encoding.
package chase_pkg;
    localparam int BANNER_W     = 20;
    localparam int BANNER_H     = 15;
    localparam int BANNER_DEPTH = 300;
    localparam int COLOR_W      = 3;

    localparam logic [COLOR_W-1:0] COLOR_TRANSPARENT = '0;

    typedef enum logic [1:0] {
        BLINK_IDLE = 2'd0,
        BLINK_ON   = 2'd1,
        BLINK_OFF  = 2'd2
    } blink_state_e;
endpackage

// File: rtl/banner_blink_fsm.sv
// Frame-synchronous blink sequencer: IDLE until show, then ON/OFF phases of
// BLINK_FRAMES frames each. State only moves at frame start.
module banner_blink_fsm
    import chase_pkg::*;
#(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start_i,
    input  logic show_i,
    output logic blink_on_o
);
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);
    localparam logic [1:0] ST_IDLE = 2'(BLINK_IDLE);
    localparam logic [1:0] ST_ON   = 2'(BLINK_ON);
    localparam logic [1:0] ST_OFF  = 2'(BLINK_OFF);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        if (!show_i) begin
            state_d     = ST_IDLE;
            frame_cnt_d = '0;
        end else begin
            case (state_q)
                ST_ON, ST_OFF: begin
                    if (frame_cnt_q == CNT_LAST) begin
                        state_d     = (state_q == ST_ON) ? ST_OFF : ST_ON;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d     = ST_ON;
                    frame_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
        end else if (frame_start_i) begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign blink_on_o = (state_q == ST_ON);
endmodule

// File: rtl/win_banner_reader.sv
// Maps the raster position inside the banner window to a ROM address using
// incremental cell counters, and registers the returned colour one tick later.
module win_banner_reader
    import chase_pkg::*;
#(
    parameter int X0           = 220,
    parameter int Y0           = 180,
    parameter int SCALE        = 8,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic [9:0]         h_cnt,
    input  logic [9:0]         v_cnt,
    input  logic               video_on,
    input  logic               show,
    output logic [8:0]         rom_addr,
    input  logic [COLOR_W-1:0] rom_q,
    output logic [COLOR_W-1:0] pix_rgb,
    output logic               pix_hit,
    output logic               blink_on
);
    localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [9:0]    X_LO     = 10'(X0);
    localparam logic [9:0]    X_HI     = 10'(X0 + BANNER_W * SCALE - 1);
    localparam logic [9:0]    Y_LO     = 10'(Y0);
    localparam logic [9:0]    Y_HI     = 10'(Y0 + BANNER_H * SCALE - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(SCALE - 1);
    localparam logic [4:0]    COL_LAST = 5'(BANNER_W - 1);
    localparam logic [3:0]    ROW_LAST = 4'(BANNER_H - 1);
    localparam logic [8:0]    ROW_STEP = 9'(BANNER_W);

    logic               in_win, line_start, line_end, v_start, frame_start;
    logic [SW-1:0]      sx_q, sx_d, sx_cur, sy_q, sy_d;
    logic [4:0]         col_q, col_d, col_cur;
    logic [3:0]         row_q, row_d;
    logic [8:0]         row_base_q, row_base_d;
    logic [8:0]         rom_addr_q, rom_addr_d;
    logic               in_win_q;
    logic [COLOR_W-1:0] pix_rgb_q, pix_rgb_d;
    logic               pix_hit_q;
    logic               blink_on_w;

    assign in_win      = video_on && (h_cnt >= X_LO) && (h_cnt <= X_HI)
                         && (v_cnt >= Y_LO) && (v_cnt <= Y_HI);
    assign line_start  = (h_cnt == X_LO);
    assign line_end    = in_win && (h_cnt == X_HI);
    assign v_start     = (v_cnt == Y_LO) && (h_cnt == 10'd0);
    assign frame_start = pix_en && (h_cnt == 10'd0) && (v_cnt == 10'd0);

    // The window's first column uses cleared counters in the same tick.
    assign sx_cur  = line_start ? '0 : sx_q;
    assign col_cur = line_start ? '0 : col_q;

    always_comb begin
        sx_d       = sx_q;
        col_d      = col_q;
        sy_d       = sy_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        rom_addr_d = rom_addr_q;
        if (line_start) begin
            sx_d  = '0;
            col_d = '0;
        end
        if (in_win) begin
            rom_addr_d = row_base_q + {4'd0, col_cur};
            if (sx_cur == S_LAST) begin
                sx_d  = '0;
                col_d = (col_cur != COL_LAST) ? col_cur + 5'd1 : col_cur;
            end else begin
                sx_d  = sx_cur + SW'(1);
                col_d = col_cur;
            end
        end
        if (v_start) begin
            sy_d       = '0;
            row_d      = '0;
            row_base_d = '0;
        end else if (line_end) begin
            if (sy_q == S_LAST) begin
                sy_d = '0;
                if (row_q != ROW_LAST) begin
                    row_d      = row_q + 4'd1;
                    row_base_d = row_base_q + ROW_STEP;
                end
            end else begin
                sy_d = sy_q + SW'(1);
            end
        end
        pix_rgb_d = (in_win_q && blink_on_w) ? rom_q : COLOR_TRANSPARENT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sx_q       <= '0;
            col_q      <= '0;
            sy_q       <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            rom_addr_q <= '0;
            in_win_q   <= 1'b0;
            pix_rgb_q  <= COLOR_TRANSPARENT;
            pix_hit_q  <= 1'b0;
        end else if (pix_en) begin
            sx_q       <= sx_d;
            col_q      <= col_d;
            sy_q       <= sy_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            rom_addr_q <= rom_addr_d;
            in_win_q   <= in_win;
            pix_rgb_q  <= pix_rgb_d;
            pix_hit_q  <= (pix_rgb_d != COLOR_TRANSPARENT);
        end
    end

    banner_blink_fsm #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk          (clk),
        .rst          (rst),
        .frame_start_i(frame_start),
        .show_i       (show),
        .blink_on_o   (blink_on_w)
    );

    assign rom_addr = rom_addr_q;
    assign pix_rgb  = pix_rgb_q;
    assign pix_hit  = pix_hit_q;
    assign blink_on = blink_on_w;
endmodule

// File: tb/tb_win_banner_reader.sv
// Randomised raster sweep of a shrunken screen against a cell-arithmetic
// reference model; expected outputs are queued per cycle and checked by a monitor.
module tb_win_banner_reader;
    import chase_pkg::*;

    localparam int X0 = 4, Y0 = 3, S = 3, BF = 3;
    localparam int H_TOT = 66, V_TOT = 50, H_VIS = 64, V_VIS = 48;
    localparam int FRAME_TICKS = H_TOT * V_TOT;
    localparam int NF = 14;

    logic       clk = 1'b0;
    logic       rst, pix_en, video_on, show;
    logic [9:0] h_cnt, v_cnt;
    logic [8:0] rom_addr;
    logic [2:0] rom_q, pix_rgb;
    logic       pix_hit, blink_on;

    logic [2:0] rom [0:BANNER_DEPTH-1];
    assign rom_q = (int'(rom_addr) < BANNER_DEPTH) ? rom[rom_addr] : 3'd0;

    always #5 clk = ~clk;

    win_banner_reader #(
        .X0(X0), .Y0(Y0), .SCALE(S), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .video_on(video_on), .show(show), .rom_addr(rom_addr), .rom_q(rom_q),
        .pix_rgb(pix_rgb), .pix_hit(pix_hit), .blink_on(blink_on)
    );

    typedef struct packed {
        logic [8:0] addr;
        logic       addr_k;
        logic [2:0] rgb;
        logic       rgb_k;
        logic       hit;
        logic       blink;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    int hr, vr;
    int m_addr, m_rgb, m_nfs;
    bit m_addr_k, m_rgb_k, m_win_d, m_active, m_vsync;

    function automatic bit model_on();
        return m_active && (((m_nfs / BF) % 2) == 0);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t, h=%0d v=%0d)",
                     name, act, req, $time, h_cnt, v_cnt);
        end
    endtask

    task automatic step(input bit r, input bit pe, input bit sh);
        bit   win, on_now;
        exp_t e;
        @(negedge clk);
        rst      = r;
        pix_en   = pe;
        show     = sh;
        h_cnt    = 10'(hr);
        v_cnt    = 10'(vr);
        video_on = (hr < H_VIS) && (vr < V_VIS);
        if (r) begin
            m_addr = 0; m_addr_k = 1; m_rgb = 0; m_rgb_k = 1;
            m_win_d = 0; m_active = 0; m_nfs = 0; m_vsync = 0;
        end else if (pe) begin
            on_now = model_on();
            if (m_win_d && on_now) begin
                m_rgb   = int'(rom[m_addr]);
                m_rgb_k = m_addr_k;
            end else begin
                m_rgb   = 0;
                m_rgb_k = 1;
            end
            if (hr == 0 && vr == Y0) m_vsync = 1;
            win = video_on && hr >= X0 && hr < X0 + BANNER_W * S
                  && vr >= Y0 && vr < Y0 + BANNER_H * S;
            if (win) begin
                if (m_vsync) begin
                    m_addr   = ((vr - Y0) / S) * BANNER_W + (hr - X0) / S;
                    m_addr_k = 1;
                end else begin
                    m_addr_k = 0;
                end
            end
            m_win_d = win;
            if (hr == 0 && vr == 0) begin
                if (!sh) m_active = 0;
                else if (!m_active) begin
                    m_active = 1;
                    m_nfs    = 0;
                end else m_nfs++;
            end
        end
        e.addr   = 9'(m_addr);
        e.addr_k = m_addr_k;
        e.rgb    = 3'(m_rgb);
        e.rgb_k  = m_rgb_k;
        e.hit    = (m_rgb != 0);
        e.blink  = model_on();
        exp_q.push_back(e);
        if (pe) begin
            hr++;
            if (hr == H_TOT) begin
                hr = 0;
                vr = (vr + 1) % V_TOT;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.addr_k) chk("rom_addr", int'(rom_addr), int'(e.addr));
                if (e.rgb_k) begin
                    chk("pix_rgb", int'(pix_rgb), int'(e.rgb));
                    chk("pix_hit", int'(pix_hit), int'(e.hit));
                end
                chk("blink_on", int'(blink_on), int'(e.blink));
            end
        end
    end

    initial begin : driver
        bit sh;
        bit stalled;
        bit rst_done;
        int rst_left;
        int tick, toggle_at, rst_at;
        for (int i = 0; i < BANNER_DEPTH; i++)
            rom[i] = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
        hr = 0; vr = 0;
        sh = 0; stalled = 0; rst_done = 0; rst_left = 0;
        rst = 1'b1; pix_en = 1'b0; show = 1'b0; video_on = 1'b0;
        h_cnt = '0; v_cnt = '0;
        repeat (3) step(1'b1, 1'b0, sh);

        for (int f = 0; f < NF; f++) begin
            toggle_at = $urandom_range(200, FRAME_TICKS - 200);
            rst_at    = $urandom_range(800, 2500);
            tick      = 0;
            while (tick < FRAME_TICKS) begin
                bit pe;
                bit r;
                if (tick == toggle_at) begin
                    case (f)
                        1:       sh = 1'b1;
                        10:      sh = 1'b0;
                        11:      sh = 1'b1;
                        default: ;
                    endcase
                end
                if (f == 2 && hr == X0 + 10 && vr == Y0 + 5 && !stalled) begin
                    stalled = 1;
                    repeat (5) step(1'b0, 1'b0, sh);
                end
                if (f == 12 && tick == rst_at && !rst_done) begin
                    rst_done = 1;
                    rst_left = 2;
                end
                r  = (rst_left > 0);
                pe = ($urandom_range(0, 7) != 0);
                step(r, pe, sh);
                if (rst_left > 0) rst_left--;
                if (pe) tick++;
            end
        end

        repeat (3) step(1'b0, 1'b0, sh);
        repeat (3) @(negedge clk);
        chk("queue_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
